vram_arbiter: RTL and testbench

Shares the single-port character/video RAM between the display fetch path and a host port. The display fetch is timed by the sync generator's `DataSource` window and always wins the port. Host writes are buffered in a small FIFO and drained in free cycles. Host reads are granted only when no writes are pending, so a read always returns the latest written data. The block sits between the sync generator / pixel pipeline and the RAM macro.

---
 rtl/vram_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display fetch > buffered host write > host read.
// Define VRAM_ARB_STATS_EN to build the saturating write-stall counter on stall_cnt.
module vram_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              DataSource,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              host_rd_valid,
  output logic              host_rd_ready,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic [DATA_W-1:0] host_rd_data,
  output logic              host_rd_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_RD   = 2'd2
  } tag_e;

  logic              dreq;
  logic              grant_disp;
  logic              grant_wr;
  logic              grant_rd;
  logic              push;
  logic              fifo_empty;
  logic              fifo_full;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  tag_e              tag_q, tag_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  assign dreq          = disp_req & DataSource;
  assign fifo_empty    = (count_q == CNT_W'(0));
  assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign host_wr_ready = !reset && !fifo_full;
  assign push          = host_wr_valid && host_wr_ready;

  always_comb begin
    grant_disp = 1'b0;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    if (!reset) begin
      if (dreq) begin
        grant_disp = 1'b1;
      end else if (!fifo_empty) begin
        grant_wr = 1'b1;
      end else if (host_rd_valid) begin
        grant_rd = 1'b1;
      end else begin
        grant_disp = 1'b0;
      end
    end else begin
      grant_disp = 1'b0;
    end
  end

  assign mem_we        = grant_wr;
  assign host_rd_ready = grant_rd;

  // Idle cycles keep presenting the last address/data to the RAM.
  always_comb begin
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if (reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (grant_disp) begin
      mem_addr = disp_addr;
    end else if (grant_wr) begin
      mem_addr  = fifo_addr_q[rd_ptr_q];
      mem_wdata = fifo_data_q[rd_ptr_q];
    end else if (grant_rd) begin
      mem_addr = host_rd_addr;
    end else begin
      mem_addr = mem_addr_q;
    end
  end

  assign mem_addr_d  = mem_addr;
  assign mem_wdata_d = mem_wdata;

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_addr_d[wr_ptr_q] = host_wr_addr;
        fifo_data_d[wr_ptr_q] = host_wr_data;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (grant_wr) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, grant_wr})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // The tag tells next cycle's return path who owns mem_rdata.
  always_comb begin
    tag_d = TAG_NONE;
    if (grant_disp) begin
      tag_d = TAG_DISP;
    end else if (grant_rd) begin
      tag_d = TAG_RD;
    end else begin
      tag_d = TAG_NONE;
    end
  end

  always_comb begin
    disp_valid   = 1'b0;
    host_rd_done = 1'b0;
    disp_data_d  = disp_data_q;
    rd_data_d    = rd_data_q;
    if (reset) begin
      disp_data_d = '0;
      rd_data_d   = '0;
    end else begin
      case (tag_q)
        TAG_DISP: begin
          disp_valid  = 1'b1;
          disp_data_d = mem_rdata;
        end
        TAG_RD: begin
          host_rd_done = 1'b1;
          rd_data_d    = mem_rdata;
        end
        default: begin
          disp_valid = 1'b0;
        end
      endcase
    end
  end

  assign disp_data    = disp_data_d;
  assign host_rd_data = rd_data_d;

  always_ff @(posedge vga_clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    count_q     <= count_d;
    mem_addr_q  <= mem_addr_d;
    mem_wdata_q <= mem_wdata_d;
    tag_q       <= tag_d;
    disp_data_q <= disp_data_d;
    rd_data_q   <= rd_data_d;
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (reset) begin
      stall_cnt_d = 16'h0000;
    end else if (dreq && !fifo_empty && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'h0001;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge vga_clk) begin
    stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural one-cycle-latency RAM.
module tb_vram_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
`ifdef VRAM_ARB_STATS_EN
  localparam int STALL_EXP = 3;
`else
  localparam int STALL_EXP = 0;
`endif

  logic              vga_clk = 1'b0;
  logic              reset;
  logic              DataSource;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              host_wr_valid;
  logic              host_wr_ready;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [DATA_W-1:0] host_wr_data;
  logic              host_rd_valid;
  logic              host_rd_ready;
  logic [ADDR_W-1:0] host_rd_addr;
  logic [DATA_W-1:0] host_rd_data;
  logic              host_rd_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       stall_cnt;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int checks = 0;
  int passed = 0;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .vga_clk(vga_clk), .reset(reset), .DataSource(DataSource),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_valid(disp_valid), .host_wr_valid(host_wr_valid),
    .host_wr_ready(host_wr_ready), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_rd_valid(host_rd_valid),
    .host_rd_ready(host_rd_ready), .host_rd_addr(host_rd_addr),
    .host_rd_data(host_rd_data), .host_rd_done(host_rd_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous single-port RAM, read-before-write, one-cycle read latency.
  always @(posedge vga_clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; DataSource = 1'b0; disp_req = 1'b0; disp_addr = '0;
    host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    host_rd_valid = 1'b1; host_rd_addr = 12'h007;
    tick(); tick();
    #1;
    chk("rst_wr_ready", host_wr_ready, 1'b0);
    chk("rst_rd_ready", host_rd_ready, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_disp_valid", disp_valid, 1'b0);
    chk("rst_rd_done", host_rd_done, 1'b0);
    chk("rst_mem_addr", mem_addr, 12'h000);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_stall", stall_cnt, 16'h0000);
    tick();
    reset = 1'b0; host_rd_valid = 1'b0;
    // write 0x010 <- 0x41
    host_wr_valid = 1'b1; host_wr_addr = 12'h010; host_wr_data = 8'h41;
    #1;
    chk("post_rst_wr_ready", host_wr_ready, 1'b1);
    chk("post_rst_disp_data", disp_data, 8'h00);
    chk("post_rst_rd_data", host_rd_data, 8'h00);
    chk("wr_not_in_accept", mem_we, 1'b0);
    tick();
    host_wr_valid = 1'b0;
    #1;
    chk("wr1_we", mem_we, 1'b1);
    chk("wr1_addr", mem_addr, 12'h010);
    chk("wr1_data", mem_wdata, 8'h41);
    tick();
    #1;
    chk("idle_we", mem_we, 1'b0);
    chk("idle_addr_hold", mem_addr, 12'h010);
    // display fetch
    DataSource = 1'b1; disp_req = 1'b1; disp_addr = 12'h010;
    #1;
    chk("disp_addr", mem_addr, 12'h010);
    chk("disp_we", mem_we, 1'b0);
    tick();
    disp_req = 1'b0;
    #1;
    chk("disp_valid", disp_valid, 1'b1);
    chk("disp_data", disp_data, 8'h41);
    tick();
    #1;
    chk("disp_valid_1cyc", disp_valid, 1'b0);
    chk("disp_data_hold", disp_data, 8'h41);
    // request outside the display window is ignored
    DataSource = 1'b0; disp_req = 1'b1; disp_addr = 12'h020;
    #1;
    chk("nowin_addr", mem_addr, 12'h010);
    tick();
    disp_req = 1'b0;
    #1;
    chk("nowin_valid", disp_valid, 1'b0);
    // write then read coherence
    host_wr_valid = 1'b1; host_wr_addr = 12'h123; host_wr_data = 8'h5A;
    tick();
    host_wr_valid = 1'b0; host_rd_valid = 1'b1; host_rd_addr = 12'h123;
    #1;
    chk("raw_drain_we", mem_we, 1'b1);
    chk("raw_drain_addr", mem_addr, 12'h123);
    chk("raw_rd_blocked", host_rd_ready, 1'b0);
    tick();
    #1;
    chk("raw_rd_ready", host_rd_ready, 1'b1);
    chk("raw_rd_addr", mem_addr, 12'h123);
    tick();
    host_rd_valid = 1'b0;
    #1;
    chk("raw_rd_done", host_rd_done, 1'b1);
    chk("raw_rd_data", host_rd_data, 8'h5A);
    tick();
    #1;
    chk("raw_rd_done_1cyc", host_rd_done, 1'b0);
    chk("raw_rd_data_hold", host_rd_data, 8'h5A);
    // fill FIFO while display holds the port
    DataSource = 1'b1; disp_req = 1'b1; disp_addr = 12'h010;
    for (int i = 0; i < 4; i++) begin
      host_wr_valid = 1'b1; host_wr_addr = 12'h200 + 12'(i); host_wr_data = 8'hA0 + 8'(i);
      #1;
      chk("full_wr_ready", host_wr_ready, 1'b1);
      chk("full_we_blocked", mem_we, 1'b0);
      tick();
    end
    host_wr_valid = 1'b0; disp_req = 1'b0;
    #1;
    chk("full_ready_low", host_wr_ready, 1'b0);
    chk("full_stall", stall_cnt, 16'(STALL_EXP));
    chk("full_disp_valid", disp_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_we", mem_we, 1'b1);
      chk("drain_addr", mem_addr, 12'h200 + 12'(i));
      chk("drain_data", mem_wdata, 8'hA0 + 8'(i));
      tick();
    end
    chk("drain_done_we", mem_we, 1'b0);
    chk("drain_ready", host_wr_ready, 1'b1);
    // collision: display, pending write, pending read
    host_wr_valid = 1'b1; host_wr_addr = 12'h300; host_wr_data = 8'h77;
    tick();
    host_wr_valid = 1'b0; disp_req = 1'b1; disp_addr = 12'h010;
    host_rd_valid = 1'b1; host_rd_addr = 12'h300;
    #1;
    chk("col_disp_addr", mem_addr, 12'h010);
    chk("col_disp_we", mem_we, 1'b0);
    chk("col_rd_blocked", host_rd_ready, 1'b0);
    tick();
    disp_req = 1'b0;
    #1;
    chk("col_wr_we", mem_we, 1'b1);
    chk("col_wr_addr", mem_addr, 12'h300);
    chk("col_rd_blocked2", host_rd_ready, 1'b0);
    chk("col_disp_valid", disp_valid, 1'b1);
    tick();
    #1;
    chk("col_rd_ready", host_rd_ready, 1'b1);
    tick();
    host_rd_valid = 1'b0;
    #1;
    chk("col_rd_done", host_rd_done, 1'b1);
    chk("col_rd_data", host_rd_data, 8'h77);
    tick();
    // reset flushes a queued write and drops a pending display return
    disp_req = 1'b1; host_wr_valid = 1'b1; host_wr_addr = 12'h400; host_wr_data = 8'h99;
    tick();
    host_wr_valid = 1'b0; reset = 1'b1;
    #1;
    chk("rst2_we", mem_we, 1'b0);
    chk("rst2_wr_ready", host_wr_ready, 1'b0);
    chk("rst2_disp_valid", disp_valid, 1'b0);
    tick();
    reset = 1'b0; disp_req = 1'b0;
    #1;
    chk("flush_we", mem_we, 1'b0);
    chk("flush_disp_valid", disp_valid, 1'b0);
    chk("flush_wr_ready", host_wr_ready, 1'b1);
    // reset in the read grant cycle
    host_rd_valid = 1'b1; host_rd_addr = 12'h123;
    #1;
    chk("rr_rd_ready", host_rd_ready, 1'b1);
    reset = 1'b1;
    #1;
    chk("rr_rd_ready_rst", host_rd_ready, 1'b0);
    tick();
    reset = 1'b0; host_rd_valid = 1'b0;
    #1;
    chk("rr_no_done", host_rd_done, 1'b0);
    chk("rr_rd_data_rst", host_rd_data, 8'h00);
    chk("rr_wr_ready", host_wr_ready, 1'b1);
    chk("rr_we", mem_we, 1'b0);
    // ten writes through the FIFO, wrapping the pointers
    for (int i = 0; i < 10; i++) begin
      host_wr_valid = 1'b1; host_wr_addr = 12'h500 + 12'(i); host_wr_data = 8'h10 + 8'(i);
      #1;
      if (i == 0) begin
        chk("wrap_first_we", mem_we, 1'b0);
      end else begin
        chk("wrap_we", mem_we, 1'b1);
        chk("wrap_addr", mem_addr, 12'h500 + 12'(i - 1));
        chk("wrap_data", mem_wdata, 8'h10 + 8'(i - 1));
      end
      tick();
    end
    host_wr_valid = 1'b0;
    #1;
    chk("wrap_last_we", mem_we, 1'b1);
    chk("wrap_last_addr", mem_addr, 12'h509);
    chk("wrap_last_data", mem_wdata, 8'h19);
    tick();
    #1;
    chk("wrap_idle_we", mem_we, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("wrap_ram", ram[12'h500 + 12'(i)], 8'h10 + 8'(i));
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
